// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI master shift engine, one DATA_W-bit full-duplex word per start.
// Optional SPI_LSB_FIRST_EN: LSB-first tx, rx filled from the MSB down.
module spi_shift_engine #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              hold_cs,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int DIV_CW  = $clog2(DIV + 1);
  localparam int EDGE_CW = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_CW-1:0]  DIV_LAST  = DIV_CW'(DIV - 1);
  localparam logic [EDGE_CW-1:0] EDGE_LAST = EDGE_CW'(2 * DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_LAG} state_t;

  state_t              state;
  logic [DIV_CW-1:0]   div_cnt;
  logic [EDGE_CW-1:0]  edge_cnt;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic tx_bit(input logic [DATA_W-1:0] v);
    return v[0];
  endfunction
  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v);
    return v >> 1;
  endfunction
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v, input logic b);
    return {b, v[DATA_W-1:1]};
  endfunction
`else
  function automatic logic tx_bit(input logic [DATA_W-1:0] v);
    return v[DATA_W-1];
  endfunction
  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v);
    return v << 1;
  endfunction
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v, input logic b);
    return {v[DATA_W-2:0], b};
  endfunction
`endif

  logic               tick;
  logic [EDGE_CW-1:0] edge_next;
  logic               sample_edge;
  logic [DATA_W-1:0]  rx_next;

  // Odd edges are leading edges; CPHA=0 samples on them, CPHA=1 on trailing ones.
  always_comb begin
    tick        = (div_cnt == DIV_LAST);
    edge_next   = edge_cnt + EDGE_CW'(1);
    sample_edge = edge_next[0] ^ CPHA;
    rx_next     = rx_shift(rx_sr, miso);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sclk      <= CPOL;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else begin
      word_done <= 1'b0;
      rx_valid  <= 1'b0;
      case (state)
        S_IDLE, S_HOLD: begin
          if (start) begin
            // CPHA=0 must present the first bit before the first (sampling) edge.
            if (!CPHA) begin
              mosi  <= tx_bit(tx_data);
              tx_sr <= tx_shift(tx_data);
            end else begin
              tx_sr <= tx_data;
            end
            state    <= S_SETUP;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else if (state == S_HOLD && !hold_cs) begin
            state   <= S_LAG;
            div_cnt <= '0;
          end
        end
        S_SETUP: begin
          edge_cnt <= '0;
          if (tick) begin
            div_cnt <= '0;
            state   <= S_SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_CW'(1);
          end
        end
        S_SHIFT: begin
          if (tick) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_next;
            if (sample_edge) begin
              rx_sr <= rx_next;
            end else if (edge_next != EDGE_LAST) begin
              mosi  <= tx_bit(tx_sr);
              tx_sr <= tx_shift(tx_sr);
            end
            if (edge_next == EDGE_LAST) begin
              rx_data   <= sample_edge ? rx_next : rx_sr;
              word_done <= 1'b1;
              rx_valid  <= 1'b1;
              state     <= hold_cs ? S_HOLD : S_LAG;
            end
          end else begin
            div_cnt <= div_cnt + DIV_CW'(1);
          end
        end
        S_LAG: begin
          if (tick) begin
            div_cnt <= '0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - directed bench: mode 0 (DIV=4) and mode 3 (DIV=1) instances.
module tb_spi_shift_engine;
  logic clk;
  logic rst;

  logic       a_start, a_hold, a_sclk, a_mosi, a_cs_n, a_rx_valid, a_word_done, a_busy;
  logic [7:0] a_tx, a_rx_data;
  logic       b_start, b_hold, b_sclk, b_mosi, b_cs_n, b_rx_valid, b_word_done, b_busy;
  logic [7:0] b_tx, b_rx_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wd_cnt = 0;
  int cs_hi_cnt = 0;

  spi_shift_engine #(.DATA_W(8), .DIV(4), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx), .hold_cs(a_hold),
    .miso(a_mosi), .sclk(a_sclk), .mosi(a_mosi), .cs_n(a_cs_n), .rx_data(a_rx_data),
    .rx_valid(a_rx_valid), .word_done(a_word_done), .busy(a_busy));

  spi_shift_engine #(.DATA_W(8), .DIV(1), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx), .hold_cs(b_hold),
    .miso(1'b1), .sclk(b_sclk), .mosi(b_mosi), .cs_n(b_cs_n), .rx_data(b_rx_data),
    .rx_valid(b_rx_valid), .word_done(b_word_done), .busy(b_busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_word_done) wd_cnt <= wd_cnt + 1;
    if (a_cs_n) cs_hi_cnt <= cs_hi_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One mode-0 word on dut_a; ign>0 pulses an extra start that many cycles in.
  task automatic word_a(input logic [7:0] tx, input logic hd, input int ign,
                        output int lat, output logic [7:0] cap, output int edges,
                        output logic m0);
    int t0;
    logic ps;
    @(negedge clk);
    a_tx = tx; a_hold = hd; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    t0 = cyc; m0 = a_mosi; lat = -1; cap = '0; edges = 0; ps = a_sclk;
    for (int i = 1; i <= 200; i++) begin
      if (i == ign) begin a_start = 1'b1; a_tx = 8'hFF; end
      @(negedge clk);
      a_start = 1'b0;
      if (a_sclk != ps) begin
        edges++;
        if (a_sclk) cap = {cap[6:0], a_mosi};
      end
      ps = a_sclk;
      if (a_word_done) begin lat = cyc - t0; break; end
    end
  endtask

  int lat, edges, wd0, cs0, viol, t0;
  logic [7:0] cap;
  logic m0, ps, pm;

  initial begin
    rst = 1'b1; a_start = 0; a_hold = 0; a_tx = 0; b_start = 0; b_hold = 0; b_tx = 0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", a_sclk, 0);
    chk("rst_cs_n", a_cs_n, 1);
    chk("rst_mosi", a_mosi, 0);
    chk("rst_rx_data", a_rx_data, 0);
    chk("rst_flags", {a_rx_valid, a_word_done, a_busy}, 0);
    chk("rst_b_sclk", b_sclk, 1);
    rst = 1'b0;

    // Mode 0 single word, loopback
    word_a(8'hA5, 1'b0, 0, lat, cap, edges, m0);
    chk("m0_first_bit", m0, 1);
    chk("m0_latency", lat, 68);
    chk("m0_edges", edges, 16);
    chk("m0_mosi_bits", cap, 8'hA5);
    chk("m0_rx_data", a_rx_data, 8'hA5);
    chk("m0_rx_valid", a_rx_valid, 1);
    chk("m0_sclk_idle", a_sclk, 0);
    @(negedge clk);
    chk("m0_pulse_width", {a_word_done, a_rx_valid}, 0);
    repeat (2) @(negedge clk);
    chk("m0_lag_cs_low", a_cs_n, 0);
    @(negedge clk);
    chk("m0_lag_cs_high", a_cs_n, 1);
    chk("m0_busy_off", a_busy, 0);

    // Ignored starts in SHIFT and LAG; bit order check with non-palindrome
    wd0 = wd_cnt;
    word_a(8'h1E, 1'b0, 20, lat, cap, edges, m0);
    chk("ign_latency", lat, 68);
    chk("ign_rx_data", a_rx_data, 8'h1E);
`ifdef SPI_LSB_FIRST_EN
    chk("ign_bit_order", cap, 8'h78);
`else
    chk("ign_bit_order", cap, 8'h1E);
`endif
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (100) @(negedge clk);
    chk("ign_wd_count", wd_cnt - wd0, 1);
    chk("ign_rx_kept", a_rx_data, 8'h1E);
    chk("ign_idle", {a_busy, a_cs_n}, 2'b01);

    // Burst: HOLD then start together with hold_cs=0
    word_a(8'h3C, 1'b1, 0, lat, cap, edges, m0);
    chk("burst1_latency", lat, 68);
    chk("burst1_rx", a_rx_data, 8'h3C);
    cs0 = cs_hi_cnt;
    word_a(8'hC3, 1'b0, 0, lat, cap, edges, m0);
    chk("burst2_latency", lat, 68);
    chk("burst2_rx", a_rx_data, 8'hC3);
    repeat (3) @(negedge clk);
    chk("burst_cs_continuous", cs_hi_cnt - cs0, 0);
    chk("burst_lag_cs_low", a_cs_n, 0);
    @(negedge clk);
    chk("burst_cs_release", a_cs_n, 1);

    // Reset mid-word after the 6th sclk edge
    @(negedge clk);
    a_tx = 8'hFF; a_hold = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; edges = 0; ps = a_sclk;
    for (int i = 0; i < 100 && edges < 6; i++) begin
      @(negedge clk);
      if (a_sclk != ps) edges++;
      ps = a_sclk;
    end
    chk("rstmid_reached6", edges, 6);
    wd0 = wd_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_cs_n", a_cs_n, 1);
    chk("rstmid_sclk", a_sclk, 0);
    chk("rstmid_busy", a_busy, 0);
    repeat (80) @(negedge clk);
    chk("rstmid_no_wd", wd_cnt - wd0, 0);
    word_a(8'h96, 1'b0, 0, lat, cap, edges, m0);
    chk("rstmid_next_latency", lat, 68);
    chk("rstmid_next_rx", a_rx_data, 8'h96);
    repeat (6) @(negedge clk);

`ifdef SPI_LSB_FIRST_EN
    word_a(8'h01, 1'b0, 0, lat, cap, edges, m0);
    chk("lsb_first_bit", m0, 1);
    chk("lsb_mosi_bits", cap, 8'h80);
    chk("lsb_rx_data", a_rx_data, 8'h01);
    repeat (6) @(negedge clk);
`endif

    // Mode 3, DIV=1, miso tied high
    @(negedge clk);
    chk("m3_idle_sclk", b_sclk, 1);
    b_tx = 8'h5A; b_hold = 1'b0; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    t0 = cyc; ps = b_sclk; pm = b_mosi; edges = 0; viol = 0; lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_sclk != ps) edges++;
      if (b_mosi != pm && !(ps && !b_sclk)) viol++;
      ps = b_sclk; pm = b_mosi;
      if (b_word_done) begin lat = cyc - t0; break; end
    end
    chk("m3_latency", lat, 17);
    chk("m3_edges", edges, 16);
    chk("m3_mosi_on_fall", viol, 0);
    chk("m3_rx_data", b_rx_data, 8'hFF);
    chk("m3_sclk_end", b_sclk, 1);
    @(negedge clk);
    @(negedge clk);
    chk("m3_cs_release", {b_cs_n, b_busy}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
